fetch_queue: RTL and testbench

//   Packet FIFO between the IFU/icache response and decoder_stage. Each entry holds one fetch

---
 rtl/fetch_queue_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 100 ++++++++++
 tb/tb_fetch_queue.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Fetch packet type shared between the fetch queue, the IFU side and decoder_stage.
package fetch_queue_pkg;

    localparam int FETCH_WIDTH = 4;
    localparam int XLEN        = 32;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0][XLEN-1:0] instr;
        logic [FETCH_WIDTH-1:0]           fetch_valid;
        logic [XLEN-1:0]                  start_pc;
        logic                             pred_taken;
        logic [1:0]                       pred_cut_pos;
        logic [XLEN-1:0]                  pred_target_pc;
    } fetch_packet_t;

    // True when the set bits form a run starting at bit 0 (including the empty mask).
    function automatic logic mask_contiguous(input logic [FETCH_WIDTH-1:0] m);
        logic [FETCH_WIDTH-1:0] inc;
        inc = m + {{(FETCH_WIDTH-1){1'b0}}, 1'b1};
        return (m & inc) == '0;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Packet FIFO between IFU/icache response and decoder_stage; flushed on redirect.
// Handshake: a transfer happens on a cycle where valid and ready are both high at the clock edge.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [FETCH_WIDTH-1:0][XLEN-1:0] in_instr,
    input  logic [FETCH_WIDTH-1:0]           in_fetch_valid,
    input  logic [XLEN-1:0]                  in_start_pc,
    input  logic                             in_pred_taken,
    input  logic [1:0]                       in_pred_cut_pos,
    input  logic [XLEN-1:0]                  in_pred_target_pc,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [FETCH_WIDTH-1:0][XLEN-1:0] out_instr,
    output logic [FETCH_WIDTH-1:0]           out_fetch_valid,
    output logic [XLEN-1:0]                  out_start_pc,
    output logic                             out_pred_taken,
    output logic [1:0]                       out_pred_cut_pos,
    output logic [XLEN-1:0]                  out_pred_target_pc,
    output logic [CNT_W-1:0]                 count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_packet_t  mem_q [DEPTH];
    logic [PTR_W:0] head_q, head_d;
    logic [PTR_W:0] tail_q, tail_d;
    logic           full, empty, push, pop;
    fetch_packet_t  in_pkt, head_pkt;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign full  = (head_q[PTR_W] != tail_q[PTR_W]) &&
                   (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]);
    assign empty = (head_q == tail_q);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready && !flush && (in_fetch_valid != '0);
    assign pop       = out_valid && out_ready && !flush;
    assign count     = tail_q - head_q;

    assign in_pkt.instr          = in_instr;
    assign in_pkt.fetch_valid    = in_fetch_valid;
    assign in_pkt.start_pc       = in_start_pc;
    assign in_pkt.pred_taken     = in_pred_taken;
    assign in_pkt.pred_cut_pos   = in_pred_cut_pos;
    assign in_pkt.pred_target_pc = in_pred_target_pc;

    assign head_pkt = empty ? '0 : mem_q[head_q[PTR_W-1:0]];

    assign out_instr          = head_pkt.instr;
    assign out_fetch_valid    = head_pkt.fetch_valid;
    assign out_start_pc       = head_pkt.start_pc;
    assign out_pred_taken     = head_pkt.pred_taken;
    assign out_pred_cut_pos   = head_pkt.pred_cut_pos;
    assign out_pred_target_pc = head_pkt.pred_target_pc;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Payload storage needs no reset: empty entries are never observed on out_*.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q[PTR_W-1:0]] <= in_pkt;
    end

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
    a_mask_contig:  assert property (@(posedge clk) disable iff (!rst_n)
                                     in_valid |-> mask_contiguous(in_fetch_valid));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomized bench for fetch_queue against a queue-based packet model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n, flush, in_valid, out_ready;
    logic in_ready, out_valid;
    logic [CNT_W-1:0] count;
    fetch_packet_t drv, obs;
    logic [FETCH_WIDTH-1:0][XLEN-1:0] out_instr;
    logic [FETCH_WIDTH-1:0] out_fetch_valid;
    logic [XLEN-1:0] out_start_pc, out_pred_target_pc;
    logic out_pred_taken;
    logic [1:0] out_pred_cut_pos;

    fetch_packet_t model_q[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(drv.instr), .in_fetch_valid(drv.fetch_valid),
        .in_start_pc(drv.start_pc), .in_pred_taken(drv.pred_taken),
        .in_pred_cut_pos(drv.pred_cut_pos), .in_pred_target_pc(drv.pred_target_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_fetch_valid(out_fetch_valid),
        .out_start_pc(out_start_pc), .out_pred_taken(out_pred_taken),
        .out_pred_cut_pos(out_pred_cut_pos), .out_pred_target_pc(out_pred_target_pc),
        .count(count)
    );

    always_comb begin
        obs.instr          = out_instr;
        obs.fetch_valid    = out_fetch_valid;
        obs.start_pc       = out_start_pc;
        obs.pred_taken     = out_pred_taken;
        obs.pred_cut_pos   = out_pred_cut_pos;
        obs.pred_target_pc = out_pred_target_pc;
    end

    task automatic check_val(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic check_pkt(input string tag, input fetch_packet_t o, input fetch_packet_t e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Compare outputs to the model, then advance one clock applying the FIFO rules.
    task automatic cycle(input string tag);
        fetch_packet_t exp_head;
        bit do_push, do_pop;
        exp_head = (model_q.size() > 0) ? model_q[0] : '0;
        check_val({tag, "_count"}, 32'(count), 32'(model_q.size()));
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'(model_q.size() < DEPTH));
        check_val({tag, "_out_valid"}, 32'(out_valid), 32'(model_q.size() > 0));
        check_pkt({tag, "_head"}, obs, exp_head);
        do_push = in_valid && (model_q.size() < DEPTH) && !flush && (drv.fetch_valid != 0);
        do_pop  = (model_q.size() > 0) && out_ready && !flush;
        @(posedge clk);
        if (flush) model_q.delete();
        else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(drv);
        end
        @(negedge clk);
    endtask

    function automatic logic [3:0] rand_mask();
        case ($urandom_range(0, 4))
            0:       return 4'b0000;
            1:       return 4'b0001;
            2:       return 4'b0011;
            3:       return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic rand_pkt(input logic [31:0] pc);
        for (int s = 0; s < FETCH_WIDTH; s++) drv.instr[s] = $urandom;
        drv.fetch_valid    = 4'b1111;
        drv.start_pc       = pc;
        drv.pred_taken     = 1'($urandom_range(0, 1));
        drv.pred_cut_pos   = 2'($urandom_range(0, 3));
        drv.pred_target_pc = $urandom;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; drv = '0;
        #12;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_pc", out_start_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("idle");

        // Single packet, held then popped.
        rand_pkt(32'h1C00_0000); in_valid = 1'b1;
        cycle("t2_push");
        in_valid = 1'b0;
        cycle("t2_hold");
        check_val("t2_pc", out_start_pc, 32'h1C00_0000);
        out_ready = 1'b1;
        cycle("t2_pop");
        cycle("t2_after");

        // Fill to full with the 9th held off, then drain in order.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            rand_pkt(32'h1C00_0000 + 32'(k) * 32'h10);
            cycle("t3_fill");
        end
        cycle("t3_hold");
        check_val("t3_full_ready", 32'(in_ready), 32'd0);
        check_val("t3_full_count", 32'(count), 32'(DEPTH));
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) check_val("t3_order", out_start_pc, 32'h1C00_0000 + 32'(k) * 32'h10);
            cycle("t3_drain");
        end

        // Streaming: one packet per cycle through a wrapping queue.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rand_pkt(32'h2000_0000 + 32'(k) * 32'h10);
            cycle("t4_stream");
            check_val("t4_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        cycle("t4_end");

        // Flush with a simultaneous input packet.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_pkt(32'h3000_0000 + 32'(k) * 32'h10);
            cycle("t5_fill");
        end
        rand_pkt(32'hDEAD_0000); flush = 1'b1;
        cycle("t5_flush");
        flush = 1'b0; in_valid = 1'b0;
        check_val("t5_count", 32'(count), 32'd0);
        check_val("t5_out_valid", 32'(out_valid), 32'd0);
        rand_pkt(32'h3100_0000); in_valid = 1'b1;
        cycle("t5_refill");
        in_valid = 1'b0; out_ready = 1'b1;
        check_val("t5_no_stale", out_start_pc, 32'h3100_0000);
        cycle("t5_drain");
        cycle("t5_empty");

        // Empty mask consumes nothing; partial mask and metadata pass through.
        out_ready = 1'b0; in_valid = 1'b1;
        rand_pkt(32'h4000_0000); drv.fetch_valid = 4'b0000;
        check_val("t6_ready", 32'(in_ready), 32'd1);
        cycle("t6_nomask");
        check_val("t6_count", 32'(count), 32'd0);
        rand_pkt(32'h4000_0010);
        drv.fetch_valid = 4'b0011; drv.pred_taken = 1'b1;
        drv.pred_cut_pos = 2'd2; drv.pred_target_pc = 32'h1C00_0100;
        cycle("t6_push");
        in_valid = 1'b0;
        check_val("t6_mask", 32'(out_fetch_valid), 32'h3);
        check_val("t6_taken", 32'(out_pred_taken), 32'd1);
        check_val("t6_cut", 32'(out_pred_cut_pos), 32'd2);
        check_val("t6_target", out_pred_target_pc, 32'h1C00_0100);
        out_ready = 1'b1;
        cycle("t6_pop");

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            rand_pkt($urandom);
            drv.fetch_valid = rand_mask();
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            cycle("rand");
        end
        flush = 1'b0;

        // Reset mid-operation clears state immediately.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rand_pkt(32'h5000_0000 + 32'(k) * 32'h10);
            cycle("t7_fill");
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        check_val("t7_count", 32'(count), 32'd0);
        check_val("t7_out_valid", 32'(out_valid), 32'd0);
        check_val("t7_in_ready", 32'(in_ready), 32'd1);
        check_val("t7_pc", out_start_pc, 32'd0);
        #1 rst_n = 1'b1;
        cycle("t7_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
